// File: rtl/sram_arb_pkg.sv
// Shared types for the two-manager SRAM data-port arbiter.
package sram_arb_pkg;

  localparam int unsigned OBI_ADDR_W = 32;
  localparam int unsigned OBI_DATA_W = 32;

  localparam logic [31:0] ERR_RDATA_DEF = 32'hDEADBEEF;

  typedef enum logic {
    MGR_CORE = 1'b0,
    MGR_HOST = 1'b1
  } mgr_id_e;

  typedef struct packed {
    logic                    req;
    logic [OBI_ADDR_W-1:0]   addr;
    logic                    we;
    logic [OBI_DATA_W/8-1:0] be;
    logic [OBI_DATA_W-1:0]   wdata;
  } obi_req_t;

endpackage

// File: rtl/sram_arb_sel.sv
// 2-way priority selector. Define SRAM_ARB_RR_EN for round-robin priority,
// otherwise manager 0 (core) always wins.
module sram_arb_sel
  import sram_arb_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] i_req,
  input  logic       i_handshake,
  output mgr_id_e    o_winner
);

  mgr_id_e w_winner;

`ifdef SRAM_ARB_RR_EN
  mgr_id_e r_prio;

  // Priority moves away from whoever just completed a handshake.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_prio <= MGR_CORE;
    end else if (i_handshake) begin
      r_prio <= mgr_id_e'(~w_winner);
    end
  end

  always_comb begin
    w_winner = MGR_CORE;
    if (i_req[1] && (!i_req[0] || (r_prio == MGR_HOST))) begin
      w_winner = MGR_HOST;
    end
  end
`else
  logic w_unused;
  assign w_unused = &{1'b0, clk_i, rst_i, i_handshake};

  always_comb begin
    w_winner = MGR_CORE;
    if (i_req[1] && !i_req[0]) begin
      w_winner = MGR_HOST;
    end
  end
`endif

  assign o_winner = w_winner;

endmodule

// File: rtl/sram_d_arbiter.sv
// Two-manager OBI arbiter in front of the SRAM data port; synthesises write
// responses and flags response protocol errors. Option: SRAM_ARB_RR_EN.
module sram_d_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned            ADDR_WIDTH = 32,
  parameter int unsigned            DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0]  ERR_RDATA  = ERR_RDATA_DEF
) (
  input  logic                    clk_i,
  input  logic                    rst_i,

  input  logic                    m0_req_i,
  output logic                    m0_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
  input  logic                    m0_we_i,
  input  logic [DATA_WIDTH/8-1:0] m0_be_i,
  input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
  output logic                    m0_rvalid_o,
  output logic [DATA_WIDTH-1:0]   m0_rdata_o,

  input  logic                    m1_req_i,
  output logic                    m1_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
  input  logic                    m1_we_i,
  input  logic [DATA_WIDTH/8-1:0] m1_be_i,
  input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
  output logic                    m1_rvalid_o,
  output logic [DATA_WIDTH-1:0]   m1_rdata_o,

  output logic                    s_req_o,
  input  logic                    s_gnt_i,
  output logic [ADDR_WIDTH-1:0]   s_addr_o,
  output logic                    s_we_o,
  output logic [DATA_WIDTH/8-1:0] s_be_o,
  output logic [DATA_WIDTH-1:0]   s_wdata_o,
  input  logic                    s_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   s_rdata_i,

  output logic                    rsp_err_o
);

  obi_req_t w_m0, w_m1, w_sel;
  mgr_id_e  w_win;
  logic     w_hs;

  assign w_m0 = '{req: m0_req_i, addr: m0_addr_i, we: m0_we_i, be: m0_be_i, wdata: m0_wdata_i};
  assign w_m1 = '{req: m1_req_i, addr: m1_addr_i, we: m1_we_i, be: m1_be_i, wdata: m1_wdata_i};

  sram_arb_sel u_sel (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .i_req       ({m1_req_i, m0_req_i}),
    .i_handshake (w_hs),
    .o_winner    (w_win)
  );

  assign w_sel = (w_win == MGR_HOST) ? w_m1 : w_m0;

  assign s_req_o   = m0_req_i | m1_req_i;
  assign s_addr_o  = w_sel.req ? w_sel.addr  : '0;
  assign s_we_o    = w_sel.req & w_sel.we;
  assign s_be_o    = w_sel.req ? w_sel.be    : '0;
  assign s_wdata_o = w_sel.req ? w_sel.wdata : '0;

  assign w_hs     = s_req_o & s_gnt_i;
  assign m0_gnt_o = (w_win == MGR_CORE) & m0_req_i & s_gnt_i;
  assign m1_gnt_o = (w_win == MGR_HOST) & m1_req_i & s_gnt_i;

  logic    r_pend_v;
  mgr_id_e r_pend_id;
  logic    r_pend_we;
  logic    r_err;
  logic    r_first;
  logic    w_err;

  // Stray rvalid is excused in the first cycle out of reset: it may be the
  // tail of a read whose response was discarded by that reset.
  always_comb begin
    w_err = 1'b0;
    if (r_pend_v) begin
      w_err = r_pend_we ? s_rvalid_i : ~s_rvalid_i;
    end else begin
      w_err = s_rvalid_i & ~r_first;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pend_v  <= 1'b0;
      r_pend_id <= MGR_CORE;
      r_pend_we <= 1'b0;
      r_err     <= 1'b0;
      r_first   <= 1'b1;
    end else begin
      r_pend_v  <= w_hs;
      r_pend_id <= w_win;
      r_pend_we <= w_sel.we;
      r_err     <= w_err;
      r_first   <= 1'b0;
    end
  end

  logic                  w_rsp_v;
  logic [DATA_WIDTH-1:0] w_rdata;

  // Gating with rst_i suppresses the response in the cycle reset is applied.
  assign w_rsp_v = r_pend_v & ~rst_i;
  assign w_rdata = r_pend_we ? '0 : (s_rvalid_i ? s_rdata_i : ERR_RDATA);

  assign m0_rvalid_o = w_rsp_v & (r_pend_id == MGR_CORE);
  assign m1_rvalid_o = w_rsp_v & (r_pend_id == MGR_HOST);
  assign m0_rdata_o  = m0_rvalid_o ? w_rdata : '0;
  assign m1_rdata_o  = m1_rvalid_o ? w_rdata : '0;
  assign rsp_err_o   = r_err;

endmodule

// File: tb/tb_sram_d_arbiter.sv
// Directed self-checking bench for sram_d_arbiter (fixed or round-robin build).
module tb_sram_d_arbiter;

`ifdef SRAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        m0_req_i, m0_gnt_o, m0_we_i, m0_rvalid_o;
  logic [31:0] m0_addr_i, m0_wdata_i, m0_rdata_o;
  logic [3:0]  m0_be_i;
  logic        m1_req_i, m1_gnt_o, m1_we_i, m1_rvalid_o;
  logic [31:0] m1_addr_i, m1_wdata_i, m1_rdata_o;
  logic [3:0]  m1_be_i;
  logic        s_req_o, s_gnt_i, s_we_o, s_rvalid_i;
  logic [31:0] s_addr_o, s_wdata_o, s_rdata_i;
  logic [3:0]  s_be_o;
  logic        rsp_err_o;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk_i = ~clk_i;

  sram_d_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ERR_RDATA(32'hDEADBEEF)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_req_i(m0_req_i), .m0_gnt_o(m0_gnt_o), .m0_addr_i(m0_addr_i), .m0_we_i(m0_we_i),
    .m0_be_i(m0_be_i), .m0_wdata_i(m0_wdata_i), .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
    .m1_req_i(m1_req_i), .m1_gnt_o(m1_gnt_o), .m1_addr_i(m1_addr_i), .m1_we_i(m1_we_i),
    .m1_be_i(m1_be_i), .m1_wdata_i(m1_wdata_i), .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
    .s_req_o(s_req_o), .s_gnt_i(s_gnt_i), .s_addr_o(s_addr_o), .s_we_o(s_we_o),
    .s_be_o(s_be_o), .s_wdata_o(s_wdata_o), .s_rvalid_i(s_rvalid_i), .s_rdata_i(s_rdata_i),
    .rsp_err_o(rsp_err_o)
  );

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic samp();
    @(negedge clk_i);
  endtask

  task automatic clear_inputs();
    m0_req_i = 0; m0_addr_i = '0; m0_we_i = 0; m0_be_i = '0; m0_wdata_i = '0;
    m1_req_i = 0; m1_addr_i = '0; m1_we_i = 0; m1_be_i = '0; m1_wdata_i = '0;
    s_gnt_i = 1; s_rvalid_i = 0; s_rdata_i = '0;
  endtask

  task automatic test_reset();
    rst_i = 1;
    clear_inputs();
    step(); step();
    samp();
    n_vec++; if (m0_rvalid_o !== 1'b0 || m1_rvalid_o !== 1'b0) begin n_err++; $display("FAIL rst_rvalid got %b%b want 00", m0_rvalid_o, m1_rvalid_o); end
    n_vec++; if (m0_rdata_o !== 32'h0 || m1_rdata_o !== 32'h0) begin n_err++; $display("FAIL rst_rdata got %h/%h want 0/0", m0_rdata_o, m1_rdata_o); end
    n_vec++; if (rsp_err_o !== 1'b0) begin n_err++; $display("FAIL rst_err got %b want 0", rsp_err_o); end
    n_vec++; if (s_req_o !== 1'b0 || s_addr_o !== 32'h0) begin n_err++; $display("FAIL rst_sreq got %b/%h want 0/0", s_req_o, s_addr_o); end
    step();
    rst_i = 0;
    samp();
  endtask

  task automatic test_m0_read();
    step();
    m0_req_i = 1; m0_addr_i = 32'h8000_0004; m0_we_i = 0; m0_be_i = 4'hF;
    samp();
    n_vec++; if (m0_gnt_o !== 1'b1 || m1_gnt_o !== 1'b0) begin n_err++; $display("FAIL t1_gnt got %b%b want 10", m0_gnt_o, m1_gnt_o); end
    n_vec++; if (s_req_o !== 1'b1 || s_addr_o !== 32'h8000_0004 || s_we_o !== 1'b0) begin n_err++; $display("FAIL t1_addr got %b/%h/%b want 1/80000004/0", s_req_o, s_addr_o, s_we_o); end
    step();
    clear_inputs(); s_rvalid_i = 1; s_rdata_i = 32'h1234_5678;
    samp();
    n_vec++; if (m0_rvalid_o !== 1'b1 || m0_rdata_o !== 32'h1234_5678) begin n_err++; $display("FAIL t1_rsp got %b/%h want 1/12345678", m0_rvalid_o, m0_rdata_o); end
    n_vec++; if (m1_rvalid_o !== 1'b0) begin n_err++; $display("FAIL t1_m1rv got %b want 0", m1_rvalid_o); end
    step();
    s_rvalid_i = 0; s_rdata_i = '0;
    samp();
    n_vec++; if (rsp_err_o !== 1'b0 || m0_rvalid_o !== 1'b0) begin n_err++; $display("FAIL t1_after got err=%b rv=%b want 0/0", rsp_err_o, m0_rvalid_o); end
  endtask

  task automatic test_m1_write();
    step();
    m1_req_i = 1; m1_addr_i = 32'h8000_0008; m1_we_i = 1; m1_be_i = 4'b0011; m1_wdata_i = 32'h0000_A5A5;
    samp();
    n_vec++; if (m1_gnt_o !== 1'b1 || m0_gnt_o !== 1'b0) begin n_err++; $display("FAIL t2_gnt got %b%b want 01", m0_gnt_o, m1_gnt_o); end
    n_vec++; if (s_we_o !== 1'b1 || s_be_o !== 4'b0011 || s_addr_o !== 32'h8000_0008 || s_wdata_o !== 32'h0000_A5A5) begin
      n_err++; $display("FAIL t2_bus got we=%b be=%b a=%h d=%h want 1/0011/80000008/0000a5a5", s_we_o, s_be_o, s_addr_o, s_wdata_o); end
    step();
    clear_inputs();
    samp();
    n_vec++; if (m1_rvalid_o !== 1'b1 || m1_rdata_o !== 32'h0 || m0_rvalid_o !== 1'b0) begin n_err++; $display("FAIL t2_rsp got %b/%h m0rv=%b want 1/0/0", m1_rvalid_o, m1_rdata_o, m0_rvalid_o); end
    step();
    samp();
    n_vec++; if (rsp_err_o !== 1'b0) begin n_err++; $display("FAIL t2_err got %b want 0", rsp_err_o); end
  endtask

  task automatic test_contention();
    logic exp_w, prev_w;
    prev_w = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      m0_req_i = 1; m0_addr_i = 32'h8000_0100; m0_we_i = 1; m0_be_i = 4'hF;
      m1_req_i = 1; m1_addr_i = 32'h8000_0200; m1_we_i = 1; m1_be_i = 4'hF;
      exp_w = RR ? i[0] : 1'b0;
      samp();
      n_vec++; if (m0_gnt_o !== ~exp_w || m1_gnt_o !== exp_w) begin n_err++; $display("FAIL t3_gnt%0d got %b%b want %b%b", i, m0_gnt_o, m1_gnt_o, ~exp_w, exp_w); end
      if (i > 0) begin
        n_vec++; if (m0_rvalid_o !== ~prev_w || m1_rvalid_o !== prev_w) begin n_err++; $display("FAIL t3_rv%0d got %b%b want %b%b", i, m0_rvalid_o, m1_rvalid_o, ~prev_w, prev_w); end
      end
      prev_w = exp_w;
    end
    step();
    clear_inputs();
    samp();
    n_vec++; if (m0_rvalid_o !== ~prev_w || m1_rvalid_o !== prev_w) begin n_err++; $display("FAIL t3_rvlast got %b%b want %b%b", m0_rvalid_o, m1_rvalid_o, ~prev_w, prev_w); end
    step();
    samp();
  endtask

  task automatic test_no_gnt();
    step();
    s_gnt_i = 0;
    m1_req_i = 1; m1_addr_i = 32'h8000_0300; m1_we_i = 1; m1_be_i = 4'hF;
    for (int i = 0; i < 3; i++) begin
      samp();
      n_vec++; if (m0_gnt_o !== 1'b0 || m1_gnt_o !== 1'b0 || m0_rvalid_o !== 1'b0 || m1_rvalid_o !== 1'b0) begin
        n_err++; $display("FAIL t4_stall%0d got gnt=%b%b rv=%b%b want 00/00", i, m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o); end
      step();
    end
    m0_req_i = 1; m0_addr_i = 32'h8000_0400;
    samp();
    n_vec++; if (s_addr_o !== 32'h8000_0400 || m0_gnt_o !== 1'b0 || m1_gnt_o !== 1'b0) begin n_err++; $display("FAIL t4_prio got %h/%b%b want 80000400/00", s_addr_o, m0_gnt_o, m1_gnt_o); end
    step();
    m0_req_i = 0; m0_addr_i = '0; s_gnt_i = 1;
    samp();
    n_vec++; if (m1_gnt_o !== 1'b1 || s_addr_o !== 32'h8000_0300) begin n_err++; $display("FAIL t4_hs got %b/%h want 1/80000300", m1_gnt_o, s_addr_o); end
    step();
    clear_inputs();
    samp();
    n_vec++; if (m1_rvalid_o !== 1'b1 || m0_rvalid_o !== 1'b0) begin n_err++; $display("FAIL t4_rsp got %b%b want 01", m0_rvalid_o, m1_rvalid_o); end
    step();
    samp();
    n_vec++; if (m1_rvalid_o !== 1'b0 || rsp_err_o !== 1'b0) begin n_err++; $display("FAIL t4_single got rv=%b err=%b want 0/0", m1_rvalid_o, rsp_err_o); end
  endtask

  task automatic test_errors();
    step();
    m0_req_i = 1; m0_addr_i = 32'h8000_0010; m0_we_i = 0; m0_be_i = 4'hF;
    samp();
    n_vec++; if (m0_gnt_o !== 1'b1) begin n_err++; $display("FAIL t5_gnt got %b want 1", m0_gnt_o); end
    step();
    clear_inputs();
    samp();
    n_vec++; if (m0_rvalid_o !== 1'b1 || m0_rdata_o !== 32'hDEADBEEF) begin n_err++; $display("FAIL t5_errdata got %b/%h want 1/deadbeef", m0_rvalid_o, m0_rdata_o); end
    n_vec++; if (rsp_err_o !== 1'b0) begin n_err++; $display("FAIL t5_errearly got %b want 0", rsp_err_o); end
    step();
    samp();
    n_vec++; if (rsp_err_o !== 1'b1) begin n_err++; $display("FAIL t5_missing got %b want 1", rsp_err_o); end
    step();
    m1_req_i = 1; m1_addr_i = 32'h8000_0020; m1_we_i = 1; m1_be_i = 4'hF;
    samp();
    n_vec++; if (rsp_err_o !== 1'b0) begin n_err++; $display("FAIL t5_pulse got %b want 0", rsp_err_o); end
    step();
    clear_inputs(); s_rvalid_i = 1; s_rdata_i = 32'h5555_AAAA;
    samp();
    n_vec++; if (m1_rvalid_o !== 1'b1 || m1_rdata_o !== 32'h0) begin n_err++; $display("FAIL t5_wrsp got %b/%h want 1/0", m1_rvalid_o, m1_rdata_o); end
    step();
    s_rvalid_i = 0;
    samp();
    n_vec++; if (rsp_err_o !== 1'b1) begin n_err++; $display("FAIL t5_wr_rv got %b want 1", rsp_err_o); end
    step();
    s_rvalid_i = 1;
    samp();
    n_vec++; if (rsp_err_o !== 1'b0 || m0_rvalid_o !== 1'b0 || m1_rvalid_o !== 1'b0) begin n_err++; $display("FAIL t5_stray0 got err=%b rv=%b%b want 0/00", rsp_err_o, m0_rvalid_o, m1_rvalid_o); end
    step();
    s_rvalid_i = 0;
    samp();
    n_vec++; if (rsp_err_o !== 1'b1) begin n_err++; $display("FAIL t5_stray got %b want 1", rsp_err_o); end
    step();
    samp();
    n_vec++; if (rsp_err_o !== 1'b0) begin n_err++; $display("FAIL t5_clear got %b want 0", rsp_err_o); end
  endtask

  task automatic test_reset_mid();
    step();
    m0_req_i = 1; m0_addr_i = 32'h8000_0030; m0_we_i = 0; m0_be_i = 4'hF;
    samp();
    step();
    clear_inputs(); rst_i = 1; s_rvalid_i = 1; s_rdata_i = 32'h0BAD_0BAD;
    samp();
    n_vec++; if (m0_rvalid_o !== 1'b0 || m1_rvalid_o !== 1'b0 || m0_rdata_o !== 32'h0) begin n_err++; $display("FAIL t6_discard got %b%b/%h want 00/0", m0_rvalid_o, m1_rvalid_o, m0_rdata_o); end
    step();
    rst_i = 0; s_rvalid_i = 1;
    samp();
    n_vec++; if (m0_rvalid_o !== 1'b0 || m1_rvalid_o !== 1'b0 || rsp_err_o !== 1'b0) begin n_err++; $display("FAIL t6_post got rv=%b%b err=%b want 00/0", m0_rvalid_o, m1_rvalid_o, rsp_err_o); end
    step();
    s_rvalid_i = 0; s_gnt_i = 0;
    m0_req_i = 1; m0_addr_i = 32'h8000_0040; m1_req_i = 1; m1_addr_i = 32'h8000_0050;
    samp();
    n_vec++; if (rsp_err_o !== 1'b0) begin n_err++; $display("FAIL t6_noerr got %b want 0", rsp_err_o); end
    n_vec++; if (s_addr_o !== 32'h8000_0040) begin n_err++; $display("FAIL t6_prio got %h want 80000040", s_addr_o); end
    step();
    clear_inputs();
    samp();
  endtask

  task automatic test_back_to_back();
    step();
    m0_req_i = 1; m0_addr_i = 32'h8000_0060; m0_we_i = 0; m0_be_i = 4'hF;
    samp();
    n_vec++; if (m0_gnt_o !== 1'b1) begin n_err++; $display("FAIL b2b_g0 got %b want 1", m0_gnt_o); end
    step();
    m0_req_i = 0; m1_req_i = 1; m1_addr_i = 32'h8000_0070; m1_we_i = 0; m1_be_i = 4'hF;
    s_rvalid_i = 1; s_rdata_i = 32'h1111_1111;
    samp();
    n_vec++; if (m1_gnt_o !== 1'b1 || m0_rvalid_o !== 1'b1 || m0_rdata_o !== 32'h1111_1111 || m1_rvalid_o !== 1'b0) begin
      n_err++; $display("FAIL b2b_c2 got g1=%b rv0=%b d0=%h rv1=%b want 1/1/11111111/0", m1_gnt_o, m0_rvalid_o, m0_rdata_o, m1_rvalid_o); end
    step();
    clear_inputs(); s_rvalid_i = 1; s_rdata_i = 32'h2222_2222;
    samp();
    n_vec++; if (m1_rvalid_o !== 1'b1 || m1_rdata_o !== 32'h2222_2222 || m0_rvalid_o !== 1'b0 || m0_rdata_o !== 32'h0) begin
      n_err++; $display("FAIL b2b_c3 got rv1=%b d1=%h rv0=%b d0=%h want 1/22222222/0/0", m1_rvalid_o, m1_rdata_o, m0_rvalid_o, m0_rdata_o); end
    step();
    s_rvalid_i = 0;
    samp();
    n_vec++; if (rsp_err_o !== 1'b0) begin n_err++; $display("FAIL b2b_err got %b want 0", rsp_err_o); end
  endtask

  initial begin
    test_reset();
    test_m0_read();
    test_m1_write();
    test_contention();
    test_no_gnt();
    test_errors();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
